grf_wb_arbiter: RTL and testbench
=================================

# grf_wb_arbiter

Write-side front end of the general register file. Merges the in-order pipeline's W-stage register write with out-of-order results from the long-latency multiply/divide unit (MDU) onto the register file's single write port. MDU results are buffered in a small FIFO. Sits between the W stage / MDU and the register file. It also reports per-register "write pending" status to the stall logic.

## Interface
- `DEPTH`, 4: MDU result FIFO entries; power of two, ≥2.
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: asynchronous, active-low; clears all state immediately on assertion.
- `w_we` in 1: W-stage write enable.
- `w_wa` in 5: W-stage destination register.
- `w_wd` in 32: W-stage write data.
- `w_pc` in 32: W-stage instruction PC, carried for the write log.
- `m_valid` in 1: MDU result valid.
- `m_ready` out 1: FIFO can accept an MDU result.
- `m_wa` in 5: MDU destination register.
- `m_wd` in 32: MDU result data.
- `m_pc` in 32: MDU instruction PC.
- `grf_wa` out 5: register file write address; 0 means no write.
- `grf_wd` out 32: register file write data.
- `grf_pc` out 32: PC of the write being committed.
- `q_a1`, `q_a2` in 5: registers queried by the stall logic.
- `q_busy1`, `q_busy2` out 1: queried register has a queued, uncommitted MDU write.
- `fifo_count` out log2(DEPTH)+1: number of stored entries.

## Operation
- **Priority.** The W stage has absolute priority and is never back-pressured. If `w_we` is 1 and `w_wa` ≠ 0, drive `grf_wa/wd/pc` = `w_wa/wd/pc`; the FIFO head is held.
- **FIFO drain.** Otherwise, if the FIFO is non-empty, drive the head entry and pop it at the next edge.
- **Idle.** Otherwise drive `grf_wa`=0, `grf_wd`=0, `grf_pc`=0.
- **Push.** An MDU push happens on an edge where `m_valid & m_ready`.
  - If `m_wa` = 0, the handshake completes but nothing is enqueued; `$0` is never written.
- **`m_ready`** = (`fifo_count` < `DEPTH`), computed from registered count only. A pop in the same cycle does not raise `m_ready`.
- **Simultaneous push and pop.** Both happen; count is unchanged; pointers wrap modulo `DEPTH`.
- **FIFO order.** Entries drain strictly in push order.
- **Busy query.** `q_busyN` = 1 iff `q_aN` ≠ 0 and some stored entry has `wa` == `q_aN`. This includes the head being popped this cycle; it excludes an entry being pushed this cycle.
- **Conflict rule.** The stall logic guarantees no W-stage write targets a register with a queued entry. The arbiter does not check this; the verification assertion is `!(w_we && w_wa!=0 && busy(w_wa))`.
- **Write log.** The register file's write log uses `grf_pc`, so committed MDU writes log the MDU instruction's PC.

## Timing
- **Outputs.** `grf_*` are combinational from W-stage inputs and the FIFO head: zero added latency. The register file samples them at the same rising edge.
- **Minimum MDU latency.** A result pushed at edge N is first driven in cycle N+1 (no bypass), so minimum push-to-commit latency is one edge.
- **Starvation.** A head entry waits while `w_we` with nonzero `w_wa` persists; there is no starvation guard. The pipeline inserts bubbles on `mfhi`/`mflo`-style dependencies.
- **Reset (`reset`=0).**
  - Pointers and count go to 0.
  - `m_ready`=1, `fifo_count`=0, `q_busy*`=0.
  - `grf_wa` is forced to 0 regardless of `w_we`.
- **Reset mid-operation.** Queued entries are discarded, never committed.
- **Full.** `m_ready`=0; `m_valid` must hold its data stable until accepted.
- **Empty with no W-stage write.** Outputs are all zero.

## Structure
- **Shared package** (`mips_pkg`):
  - register-address width 5 and data width 32;
  - the FIFO entry layout {wa[4:0], wd[31:0], pc[31:0]} = 69 bits;
  - the `REG_ZERO` = 5'd0 constant.
- **Sub-module `wb_fifo`:** synchronous FIFO with async active-low reset.
  - Ports: push, pop, head, count, and a flat view of entry `wa` fields for the busy compare.
- **Top level:** the priority mux and busy comparators.

## Test plan
1. **Reset.** Assert `reset`=0 with `w_we`=1, `w_wa`=5 → `grf_wa`=0, `m_ready`=1, `fifo_count`=0. Release → `grf_wa`=5 the same cycle.
2. **Idle drain.** Push MDU {wa=8, wd=0x1234, pc=0x3000} with no W traffic → `q_busy` for 8 is 1 for exactly one cycle. In the next cycle `grf_wa`=8, `grf_wd`=0x1234, `grf_pc`=0x3000; after that edge `fifo_count`=0.
3. **Priority.** Queue wa=9, then hold `w_we`=1, `w_wa`=3 for 3 cycles → `grf_wa`=3 throughout and reg 9 stays busy. It commits the cycle `w_we` drops.
4. **Full.** Push 4 entries (wa=1..4) while W is busy → `m_ready`=0 and `fifo_count`=4. A 5th `m_valid` stalls. Free W → drain order 1,2,3,4, then the 5th entry.
5. **Simultaneous push/pop at count=2.** Count stays 2. Run 10 cycles to exercise pointer wrap → all data committed in order.
6. **Zero register and mid-flight reset.** `m_wa`=0 push → handshake completes, `fifo_count` unchanged, no write. Reset with 3 entries queued → none ever appears on `grf_wa`.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mips_pkg
// Brief   : Shared widths, register-zero constant and write-back entry layout.
// Revision: 1.0
// ============================================================================
package mips_pkg;

    localparam int REG_AW = 5;
    localparam int DATA_W = 32;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    // {wa, wd, pc} = 69 bits, wa in the top bits
    typedef struct packed {
        logic [REG_AW-1:0] wa;
        logic [DATA_W-1:0] wd;
        logic [DATA_W-1:0] pc;
    } wb_entry_t;

    localparam int ENTRY_W = $bits(wb_entry_t);

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module  : wb_fifo
// Brief   : MDU result FIFO with occupancy-masked view of every slot's wa.
// Revision: 1.0
// ============================================================================
module wb_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  wb_entry_t               push_entry,
    input  logic                    pop,
    output wb_entry_t               head,
    output logic [CW-1:0]           count,
    output logic [DEPTH*REG_AW-1:0] wa_flat
);

    wb_entry_t     mem_q [DEPTH];
    wb_entry_t     mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic push_ok;
    logic pop_ok;

    assign push_ok = push && (count_q < CW'(DEPTH));
    assign pop_ok  = pop && (count_q != '0);

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

    // Unoccupied slots report REG_ZERO so stale data never looks busy.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        logic [PW-1:0] slot_off;
        assign slot_off = PW'(gi) - rd_ptr_q;
        assign wa_flat[gi*REG_AW +: REG_AW] =
            ({1'b0, slot_off} < count_q) ? mem_q[gi].wa : REG_ZERO;
    end

endmodule
`default_nettype wire

// File: rtl/grf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : grf_wb_arbiter
// Brief   : Merges W-stage writes and queued MDU results onto the GRF port.
// Revision: 1.0
// ============================================================================
module grf_wb_arbiter
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  w_we,
    input  logic [REG_AW-1:0]     w_wa,
    input  logic [DATA_W-1:0]     w_wd,
    input  logic [DATA_W-1:0]     w_pc,
    input  logic                  m_valid,
    output logic                  m_ready,
    input  logic [REG_AW-1:0]     m_wa,
    input  logic [DATA_W-1:0]     m_wd,
    input  logic [DATA_W-1:0]     m_pc,
    output logic [REG_AW-1:0]     grf_wa,
    output logic [DATA_W-1:0]     grf_wd,
    output logic [DATA_W-1:0]     grf_pc,
    input  logic [REG_AW-1:0]     q_a1,
    input  logic [REG_AW-1:0]     q_a2,
    output logic                  q_busy1,
    output logic                  q_busy2,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic                    w_write;
    logic                    fifo_push;
    logic                    fifo_pop;
    wb_entry_t               push_entry;
    wb_entry_t               head;
    logic [CW-1:0]           count;
    logic [DEPTH*REG_AW-1:0] wa_flat;

    assign w_write    = w_we && (w_wa != REG_ZERO);
    assign m_ready    = (count < CW'(DEPTH));
    // Zero-destination results complete the handshake but are dropped.
    assign fifo_push  = m_valid && m_ready && (m_wa != REG_ZERO);
    assign push_entry = '{wa: m_wa, wd: m_wd, pc: m_pc};
    assign fifo_count = count;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .head       (head),
        .count      (count),
        .wa_flat    (wa_flat)
    );

    // W stage wins outright; the FIFO head only drains in W-stage bubbles.
    always_comb begin
        grf_wa   = REG_ZERO;
        grf_wd   = '0;
        grf_pc   = '0;
        fifo_pop = 1'b0;
        if (reset) begin
            if (w_write) begin
                grf_wa = w_wa;
                grf_wd = w_wd;
                grf_pc = w_pc;
            end else if (count != '0) begin
                grf_wa   = head.wa;
                grf_wd   = head.wd;
                grf_pc   = head.pc;
                fifo_pop = 1'b1;
            end
        end
    end

    always_comb begin
        q_busy1 = 1'b0;
        q_busy2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((q_a1 != REG_ZERO) && (wa_flat[i*REG_AW +: REG_AW] == q_a1)) begin
                q_busy1 = 1'b1;
            end
            if ((q_a2 != REG_ZERO) && (wa_flat[i*REG_AW +: REG_AW] == q_a2)) begin
                q_busy2 = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_grf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_grf_wb_arbiter
// Brief   : Vector table, directed corner sequences and random run vs queue model.
// Revision: 1.0
// ============================================================================
module tb_grf_wb_arbiter;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        w_we;
    logic [4:0]  w_wa;
    logic [31:0] w_wd, w_pc;
    logic        m_valid, m_ready;
    logic [4:0]  m_wa;
    logic [31:0] m_wd, m_pc;
    logic [4:0]  grf_wa;
    logic [31:0] grf_wd, grf_pc;
    logic [4:0]  q_a1, q_a2;
    logic        q_busy1, q_busy2;
    logic [2:0]  fifo_count;

    grf_wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .w_we       (w_we),
        .w_wa       (w_wa),
        .w_wd       (w_wd),
        .w_pc       (w_pc),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_wa       (m_wa),
        .m_wd       (m_wd),
        .m_pc       (m_pc),
        .grf_wa     (grf_wa),
        .grf_wd     (grf_wd),
        .grf_pc     (grf_pc),
        .q_a1       (q_a1),
        .q_a2       (q_a2),
        .q_busy1    (q_busy1),
        .q_busy2    (q_busy2),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] pc;
    } ent_t;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wwa;
        logic [31:0] wwd, wpc;
        logic        mv;
        logic [4:0]  mwa;
        logic [31:0] mwd, mpc;
        logic [4:0]  qa;
        logic [4:0]  e_wa;
        logic [31:0] e_wd, e_pc;
        logic        e_rdy;
        int          e_cnt;
        logic        e_busy;
    } vec_t;

    ent_t       mq[$];
    logic [4:0] log_q[$];
    vec_t       vt[$];
    int         checks = 0;
    int         errors = 0;
    bit         accepted = 1'b1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic bit in_q(logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].wa == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic vec_t mk(logic rst, logic we, logic [4:0] wwa, logic [31:0] wwd,
                                logic [31:0] wpc, logic mv, logic [4:0] mwa,
                                logic [31:0] mwd, logic [31:0] mpc, logic [4:0] qa,
                                logic [4:0] e_wa, logic [31:0] e_wd, logic [31:0] e_pc,
                                logic e_rdy, int e_cnt, logic e_busy);
        vec_t v;
        v = '{rst, we, wwa, wwd, wpc, mv, mwa, mwd, mpc, qa, e_wa, e_wd, e_pc, e_rdy, e_cnt, e_busy};
        return v;
    endfunction

    // Called at the falling edge with inputs applied; returns at the next falling edge.
    task automatic run_cycle();
        logic        ww;
        logic [4:0]  ewa;
        logic [31:0] ewd, epc;
        int          sz;
        bit          dpop, dpush;
        #1;
        if (!rst_n) mq.delete();
        ww  = w_we && (w_wa != 5'd0);
        ewa = '0; ewd = '0; epc = '0;
        if (rst_n) begin
            if (ww) begin
                ewa = w_wa; ewd = w_wd; epc = w_pc;
            end else if (mq.size() > 0) begin
                ewa = mq[0].wa; ewd = mq[0].wd; epc = mq[0].pc;
            end
        end
        chk("grf_wa", 32'(grf_wa), 32'(ewa));
        chk("grf_wd", grf_wd, ewd);
        chk("grf_pc", grf_pc, epc);
        chk("m_ready", 32'(m_ready), 32'(mq.size() < DEPTH));
        chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
        chk("q_busy1", 32'(q_busy1), 32'(in_q(q_a1)));
        chk("q_busy2", 32'(q_busy2), 32'(in_q(q_a2)));
        if (rst_n && !ww && grf_wa != 5'd0) log_q.push_back(grf_wa);
        sz       = mq.size();
        accepted = rst_n && m_valid && (sz < DEPTH);
        dpop     = rst_n && !ww && (sz > 0);
        dpush    = accepted && (m_wa != 5'd0);
        @(posedge clk);
        if (dpop) void'(mq.pop_front());
        if (dpush) mq.push_back(ent_t'{m_wa, m_wd, m_pc});
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        w_we = 0; w_wa = 0; w_wd = 0; w_pc = 0;
        m_valid = 0; m_wa = 0; m_wd = 0; m_pc = 0;
        q_a1 = 0; q_a2 = 0;
    endtask

    initial begin
        logic [4:0] exp_log[$];
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);

        // reset, idle drain, W-stage priority
        vt.push_back(mk(0, 1, 5, 32'hAA, 32'h100, 0, 0, 0, 0, 8, 0, 0, 0, 1, 0, 0));
        vt.push_back(mk(1, 1, 5, 32'hAA, 32'h100, 0, 0, 0, 0, 8, 5, 32'hAA, 32'h100, 1, 0, 0));
        vt.push_back(mk(1, 0, 0, 0, 0, 1, 8, 32'h1234, 32'h3000, 8, 0, 0, 0, 1, 0, 0));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 8, 8, 32'h1234, 32'h3000, 1, 1, 1));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 8, 0, 0, 0, 1, 0, 0));
        vt.push_back(mk(1, 0, 0, 0, 0, 1, 9, 32'h99, 32'h4000, 9, 0, 0, 0, 1, 0, 0));
        for (int k = 0; k < 3; k++)
            vt.push_back(mk(1, 1, 3, 32'h33, 32'h200, 0, 0, 0, 0, 9, 3, 32'h33, 32'h200, 1, 1, 1));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 9, 9, 32'h99, 32'h4000, 1, 1, 1));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 1, 0, 0));

        foreach (vt[i]) begin
            rst_n = vt[i].rst; w_we = vt[i].we; w_wa = vt[i].wwa;
            w_wd = vt[i].wwd; w_pc = vt[i].wpc; m_valid = vt[i].mv;
            m_wa = vt[i].mwa; m_wd = vt[i].mwd; m_pc = vt[i].mpc;
            q_a1 = vt[i].qa; q_a2 = 0;
            #1;
            chk($sformatf("vec%0d_grf_wa", i), 32'(grf_wa), 32'(vt[i].e_wa));
            chk($sformatf("vec%0d_grf_wd", i), grf_wd, vt[i].e_wd);
            chk($sformatf("vec%0d_grf_pc", i), grf_pc, vt[i].e_pc);
            chk($sformatf("vec%0d_m_ready", i), 32'(m_ready), 32'(vt[i].e_rdy));
            chk($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(vt[i].e_cnt));
            chk($sformatf("vec%0d_busy1", i), 32'(q_busy1), 32'(vt[i].e_busy));
            run_cycle();
        end

        // full FIFO while W is busy, fifth result stalls, then drain order
        idle_inputs();
        log_q.delete();
        w_we = 1; w_wa = 20; w_wd = 32'hD0; w_pc = 32'h600;
        for (int k = 1; k <= 4; k++) begin
            m_valid = 1; m_wa = 5'(k); m_wd = 32'(k * 16); m_pc = 32'h5000 + 32'(k * 4);
            run_cycle();
        end
        m_wa = 5; m_wd = 32'h50; m_pc = 32'h5014;
        for (int k = 0; k < 2; k++) begin
            run_cycle();
            chk("full_stall_accept", 32'(accepted), 32'd0);
        end
        w_we = 0;
        for (int k = 0; k < 12; k++) begin
            run_cycle();
            if (accepted) m_valid = 0;
        end
        chk("full_accepted_5th", 32'(m_valid), 32'd0);
        exp_log = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5};
        chk("full_drain_len", 32'(log_q.size()), 32'(exp_log.size()));
        foreach (exp_log[i])
            if (i < log_q.size()) chk($sformatf("full_drain_%0d", i), 32'(log_q[i]), 32'(exp_log[i]));

        // steady push+pop at count 2 across pointer wrap
        idle_inputs();
        log_q.delete();
        exp_log.delete();
        w_we = 1; w_wa = 21;
        for (int k = 0; k < 2; k++) begin
            m_valid = 1; m_wa = 5'(10 + k); m_wd = 32'(k); m_pc = 32'h7000 + 32'(k);
            exp_log.push_back(m_wa);
            run_cycle();
        end
        w_we = 0; q_a1 = 10; q_a2 = 12;
        for (int k = 0; k < 10; k++) begin
            m_valid = 1; m_wa = 5'(12 + k); m_wd = 32'(k + 2); m_pc = 32'h7000 + 32'(k + 2);
            exp_log.push_back(m_wa);
            run_cycle();
            chk("wrap_count", 32'(fifo_count), 32'd2);
        end
        m_valid = 0;
        for (int k = 0; k < 4; k++) run_cycle();
        chk("wrap_len", 32'(log_q.size()), 32'(exp_log.size()));
        foreach (exp_log[i])
            if (i < log_q.size()) chk($sformatf("wrap_%0d", i), 32'(log_q[i]), 32'(exp_log[i]));

        // zero-register push, then reset with three entries queued
        idle_inputs();
        log_q.delete();
        m_valid = 1; m_wa = 0; m_wd = 32'hDEAD; m_pc = 32'h8000;
        run_cycle();
        chk("zero_handshake", 32'(accepted), 32'd1);
        m_valid = 0;
        run_cycle();
        w_we = 1; w_wa = 22;
        for (int k = 0; k < 3; k++) begin
            m_valid = 1; m_wa = 5'(27 + k); m_wd = 32'(k); m_pc = 32'h9000;
            run_cycle();
        end
        chk("pre_reset_count", 32'(fifo_count), 32'd3);
        m_valid = 0;
        rst_n = 0;
        run_cycle();
        rst_n = 1; w_we = 0;
        for (int k = 0; k < 5; k++) run_cycle();
        chk("reset_discard_len", 32'(log_q.size()), 32'd0);

        // randomized traffic honouring the stall-logic conflict guarantee
        idle_inputs();
        accepted = 1;
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            if (accepted || !m_valid) begin
                m_valid = $urandom_range(0, 1);
                m_wa    = 5'($urandom_range(0, 7));
                m_wd    = $urandom;
                m_pc    = $urandom;
            end
            w_we = ($urandom_range(0, 2) == 0);
            w_wa = 5'($urandom_range(0, 31));
            w_wd = $urandom;
            w_pc = $urandom;
            if (in_q(w_wa)) w_wa = 5'd0;
            q_a1 = 5'($urandom_range(0, 7));
            q_a2 = 5'($urandom_range(0, 7));
            run_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
